// File: rtl/exec_datapath.sv
// Execution datapath: register bank with hardwired-zero x0, ALU, registered result/zero flag,
// write-back pulse and program counter. Driven cycle by cycle by the control FSM.
module exec_datapath #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              reset_wire,
  input  logic [2:0]        operacao,
  input  logic              writeReg,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  output logic [DATA_W-1:0] rd1_data,
  output logic [DATA_W-1:0] rd2_data,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              wb_valid,
  output logic [DATA_W-1:0] pc
);

  localparam logic [2:0] OpNop  = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b001;
  localparam logic [2:0] OpSub  = 3'b010;
  localparam logic [2:0] OpAnd  = 3'b011;
  localparam logic [2:0] OpOr   = 3'b100;
  localparam logic [2:0] OpXor  = 3'b101;
  localparam logic [2:0] OpSlt  = 3'b110;
  localparam logic [2:0] OpPass = 3'b111;

  // x0 is not stored at all; entries 1..NREGS-1 only.
  logic [DATA_W-1:0] regs_q [1:NREGS-1];
  logic [DATA_W-1:0] alu_q, alu_d;
  logic              zero_q;
  logic              wb_valid_q;
  logic [DATA_W-1:0] pc_q;

  logic [DATA_W-1:0] op_a, op_b;

  // Register reads by address match: x0 and out-of-range addresses fall through to 0.
  always_comb begin
    rd1_data = '0;
    rd2_data = '0;
    for (int i = 1; i < int'(NREGS); i++) begin
      if (rs1 == ADDR_W'(i)) rd1_data = regs_q[i];
      if (rs2 == ADDR_W'(i)) rd2_data = regs_q[i];
    end
  end

  assign op_a = rd1_data;
  assign op_b = use_imm ? imm : rd2_data;

  // ALU, all results modulo 2^DATA_W.
  always_comb begin
    alu_d = '0;
    case (operacao)
      OpNop:   alu_d = '0;
      OpAdd:   alu_d = op_a + op_b;
      OpSub:   alu_d = op_a - op_b;
      OpAnd:   alu_d = op_a & op_b;
      OpOr:    alu_d = op_a | op_b;
      OpXor:   alu_d = op_a ^ op_b;
      OpSlt:   alu_d = ($signed(op_a) < $signed(op_b)) ? DATA_W'(1) : '0;
      OpPass:  alu_d = op_b;
      default: alu_d = '0;
    endcase
  end

  // Register bank write-back; reset_wire wins over writeReg.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 1; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (reset_wire) begin
      for (int i = 1; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else if (writeReg) begin
      for (int i = 1; i < int'(NREGS); i++) begin
        if (rd == ADDR_W'(i)) regs_q[i] <= alu_d;
      end
    end
  end

  // Result, zero flag, write-back pulse and PC.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alu_q      <= '0;
      zero_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      pc_q       <= '0;
    end else if (reset_wire) begin
      alu_q      <= '0;
      zero_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      pc_q       <= '0;
    end else begin
      alu_q      <= alu_d;
      zero_q     <= (alu_d == '0);
      wb_valid_q <= writeReg;
      // PC advances even for discarded writes to x0 or out-of-range rd.
      if (writeReg) pc_q <= pc_q + DATA_W'(4);
    end
  end

  assign alu_result = alu_q;
  assign zero       = zero_q;
  assign wb_valid   = wb_valid_q;
  assign pc         = pc_q;

endmodule
